// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Function : Data-memory initiator; splits misaligned accesses into two word
//            beats and merges/extends load data into a single response.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE0 = 3'd1,
        S_WAIT0  = 3'd2,
        S_ISSUE1 = 3'd3,
        S_WAIT1  = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [2:0]              f3_q, f3_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   d0_q, d0_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [BE_W-1:0]         mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;

    logic                    accept;
    logic                    src_we;
    logic [2:0]              src_f3;
    logic [ADDR_WIDTH-1:0]   src_addr;
    logic [DATA_WIDTH-1:0]   src_wdata;
    logic [OFF_W-1:0]        off;
    logic [BE_W-1:0]         size_mask;
    logic [2*BE_W-1:0]       be_wide;
    logic [2*DATA_WIDTH-1:0] wdata_wide;
    logic                    split;
    logic                    legal;
    logic [ADDR_WIDTH-1:0]   beat0_addr, beat1_addr;
    logic [DATA_WIDTH-1:0]   beat_lo, beat_hi, raw, ext, load_result;

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // Geometry is derived from the live request while idle, from the latched copy afterwards.
    always_comb begin
        if (state_q == S_IDLE) begin
            src_we    = req_we;
            src_f3    = req_funct3;
            src_addr  = req_addr;
            src_wdata = req_wdata;
        end else begin
            src_we    = we_q;
            src_f3    = f3_q;
            src_addr  = addr_q;
            src_wdata = wdata_q;
        end
        off = src_addr[OFF_W-1:0];
        case (src_f3[1:0])
            2'b00:   size_mask = BE_W'(1);
            2'b01:   size_mask = BE_W'(3);
            default: size_mask = BE_W'(15);
        endcase
        be_wide    = {{BE_W{1'b0}}, size_mask} << off;
        wdata_wide = {{DATA_WIDTH{1'b0}}, src_wdata} << {off, 3'b000};
        split      = |be_wide[2*BE_W-1:BE_W];
        beat0_addr = {src_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        beat1_addr = beat0_addr + ADDR_WIDTH'(BE_W);
        case (src_f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !src_we;
            default:                legal = 1'b0;
        endcase
    end

    // The upper half of the merge window is only populated by the second beat.
    always_comb begin
        if (state_q == S_WAIT1) begin
            beat_lo = d0_q;
            beat_hi = mem_rdata;
        end else begin
            beat_lo = mem_rdata;
            beat_hi = '0;
        end
        raw = DATA_WIDTH'({beat_hi, beat_lo} >> {off, 3'b000});
        case (f3_q)
            3'b000:  ext = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
            3'b100:  ext = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
            3'b001:  ext = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
            3'b101:  ext = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
            default: ext = raw;
        endcase
        load_result = we_q ? '0 : ext;
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        d0_d         = d0_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (legal) begin
                        state_d     = S_ISSUE0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_be_d    = be_wide[BE_W-1:0];
                        mem_addr_d  = beat0_addr;
                        mem_wdata_d = wdata_wide[DATA_WIDTH-1:0];
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            S_ISSUE0: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (mem_rvalid) begin
                    if (split) begin
                        d0_d        = mem_rdata;
                        state_d     = S_ISSUE1;
                        mem_req_d   = 1'b1;
                        mem_be_d    = be_wide[2*BE_W-1:BE_W];
                        mem_addr_d  = beat1_addr;
                        mem_wdata_d = wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH];
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_result;
                        resp_err_d   = 1'b0;
                    end
                end
            end
            S_ISSUE1: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_result;
                    resp_err_d   = 1'b0;
                end
            end
            S_RESP: begin
                state_d      = S_IDLE;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            d0_q         <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            d0_q         <= d0_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Function : Randomized self-checking bench for load_store_unit against a
//            byte-level memory reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 64-byte memory; every bus address aliases into it modulo 64
    logic [7:0]  mem_b [64];
    logic [31:0] b_addr [2];
    logic [3:0]  b_be [2];
    logic [31:0] b_wdata [2];
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] read_word(input logic [31:0] a);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = mem_b[6'(a + 32'(j))];
        return w;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int j = 0; j < 4; j++) mem_b[6'(a + 32'(j))] = w[8*j +: 8];
    endtask

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int gd, input int rd, input bit stray);
        int          n, exp_beats, exp_lat, beats, phase, wcnt, lat, diff;
        logic        legal, got, r_err;
        logic [31:0] raw, exp_rdata, r_data, ba, rel, ewd, wmask, beat_word;
        logic [31:0] h_addr, h_wd;
        logic [3:0]  eb, h_be;
        logic [7:0]  shadow [64];

        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ||
                (!we && (f3 == 3'b100 || f3 == 3'b101));
        exp_beats = !legal ? 0 : ((int'(addr[1:0]) + n > 4) ? 2 : 1);
        exp_lat   = !legal ? 1 : exp_beats * (2 + gd + rd) + 1;
        shadow = mem_b;
        raw = '0;
        for (int i = 0; i < n; i++) raw[8*i +: 8] = mem_b[6'(addr + 32'(i))];
        case (f3)
            3'b000:  exp_rdata = {{24{raw[7]}}, raw[7:0]};
            3'b100:  exp_rdata = {24'b0, raw[7:0]};
            3'b001:  exp_rdata = {{16{raw[15]}}, raw[15:0]};
            3'b101:  exp_rdata = {16'b0, raw[15:0]};
            default: exp_rdata = raw;
        endcase
        if (!legal || we) exp_rdata = '0;
        if (legal && we)
            for (int i = 0; i < n; i++) shadow[6'(addr + 32'(i))] = wdata[8*i +: 8];

        @(negedge clk);
        check("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        beats = 0; phase = 0; wcnt = 0; got = 1'b0; lat = 0;
        r_data = '0; r_err = 1'b0; beat_word = '0;
        h_addr = '0; h_be = '0; h_wd = '0;
        for (int c = 1; c < 100 && !got; c++) begin
            @(negedge clk);
            req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (resp_valid) begin
                got = 1'b1; lat = c; r_data = resp_rdata; r_err = resp_err;
            end else if (phase == 0) begin
                if (mem_req) begin
                    if (stray) begin
                        mem_rvalid = 1'b1; req_valid = 1'b1; req_funct3 = 3'b011;
                        check("busy_ready", {31'b0, req_ready}, 32'd0);
                    end
                    if (wcnt == 0) begin h_addr = mem_addr; h_be = mem_be; h_wd = mem_wdata; end
                    if (wcnt == gd) begin
                        if (gd > 0) begin
                            check("hold_addr", mem_addr, h_addr);
                            check("hold_be", {28'b0, mem_be}, {28'b0, h_be});
                            check("hold_wdata", mem_wdata, h_wd);
                        end
                        ba = {addr[31:2], 2'b00} + ((beats == 0) ? 32'd0 : 32'd4);
                        eb = '0; ewd = '0; wmask = '0;
                        for (int j = 0; j < 4; j++) begin
                            rel = ba + 32'(j) - addr;
                            if (rel < 32'(n)) begin
                                eb[j] = 1'b1;
                                ewd[8*j +: 8] = wdata[8*rel[1:0] +: 8];
                                wmask[8*j +: 8] = 8'hFF;
                            end
                        end
                        check("beat_addr", mem_addr, ba);
                        check("beat_be", {28'b0, mem_be}, {28'b0, eb});
                        check("beat_we", {31'b0, mem_we}, {31'b0, we});
                        if (we) check("beat_wdata", mem_wdata & wmask, ewd);
                        if (beats < 2) begin
                            b_addr[beats] = mem_addr; b_be[beats] = mem_be; b_wdata[beats] = mem_wdata;
                        end
                        beat_word = read_word(mem_addr);
                        if (mem_we)
                            for (int j = 0; j < 4; j++)
                                if (mem_be[j]) mem_b[6'(mem_addr + 32'(j))] = mem_wdata[8*j +: 8];
                        mem_gnt = 1'b1;
                        beats++; phase = 1; wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                if (wcnt == 0) check("req_drop", {31'b0, mem_req}, 32'd0);
                if (wcnt == rd) begin
                    mem_rvalid = 1'b1; mem_rdata = beat_word; phase = 0; wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
        check("timeout", {31'b0, got}, 32'd1);
        check("beats", beats, exp_beats);
        check("latency", lat, exp_lat);
        check("rdata", r_data, exp_rdata);
        check("err", {31'b0, r_err}, {31'b0, !legal});
        diff = 0;
        for (int j = 0; j < 64; j++) if (mem_b[j] !== shadow[j]) diff++;
        check("mem_bytes", diff, 0);
        last_rdata = r_data;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; req_valid = 1'b0;
        check("resp_pulse", {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] raddr;

        for (int j = 0; j < 64; j++) mem_b[j] = 8'($urandom);
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_txn(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 0, 0, 1'b0);
        check("sw_wdata", b_wdata[0], 32'hDEADBEEF);
        check("sw_be", {28'b0, b_be[0]}, 32'hF);

        set_word(32'h08, 32'h80FF0000);
        run_txn(1'b0, 3'b000, 32'h0B, 32'h0, 0, 0, 1'b0);
        check("lb_val", last_rdata, 32'hFFFFFF80);
        run_txn(1'b0, 3'b100, 32'h0B, 32'h0, 0, 0, 1'b0);
        check("lbu_val", last_rdata, 32'h00000080);
        run_txn(1'b0, 3'b101, 32'h0A, 32'h0, 0, 0, 1'b0);
        check("lhu_val", last_rdata, 32'h000080FF);

        set_word(32'h04, 32'h332211AA);
        set_word(32'h08, 32'hBBCCDD44);
        run_txn(1'b0, 3'b010, 32'h05, 32'h0, 0, 0, 1'b0);
        check("lw_split_val", last_rdata, 32'h44332211);

        run_txn(1'b1, 3'b001, 32'h0F, 32'h0000ABCD, 0, 0, 1'b0);
        check("sh_b0_wdata", b_wdata[0], 32'hCD000000);
        check("sh_b1_wdata", b_wdata[1], 32'h000000AB);
        check("sh_b1_addr", b_addr[1], 32'h10);

        run_txn(1'b0, 3'b010, 32'h20, 32'h0, 3, 0, 1'b1);
        run_txn(1'b0, 3'b011, 32'h20, 32'h0, 0, 0, 1'b0);
        run_txn(1'b1, 3'b100, 32'h20, 32'h1234, 0, 0, 1'b0);
        run_txn(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1, 1, 1'b0);

        // Reset while a beat is still waiting for its grant
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        check("issue_req", {31'b0, mem_req}, 32'd1);
        reset = 1'b1; #1;
        check("async_req_drop", {31'b0, mem_req}, 32'd0);
        check("rst_busy_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0; #1;
        check("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Reset in WAIT0: late rvalid must not produce a response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14;
        @(negedge clk);
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        reset = 1'b1; #1;
        check("wait0_rst_req", {31'b0, mem_req}, 32'd0);
        check("wait0_rst_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            check("post_rst_resp", {31'b0, resp_valid}, 32'd0);
        end
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);

        for (int t = 0; t < 150; t++) begin
            rwe   = 1'($urandom);
            rf3   = 3'($urandom);
            raddr = $urandom;
            if ($urandom_range(0, 7) == 0) raddr = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            run_txn(rwe, rf3, raddr, $urandom, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
